instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h00000000, fetch address loaded at reset.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 imem_req  out  1  instruction memory read request.
REQ-006 imem_addr  out  32  word-aligned fetch address; bits [1:0] always 0.
REQ-007 imem_ack  in  1  memory has imem_data valid this cycle.
REQ-008 imem_data  in  32  fetched instruction word.
REQ-009 instr  out  32  instruction presented to the decoder.
REQ-010 instr_valid  out  1  instr is valid and the decoder's controls refer to it.
REQ-011 pc_out  out  32  address of instr.
REQ-012 pc_plus4  out  32  pc_out+4, used as the link value for JAL/JALR.
REQ-013 stall  in  1  downstream hold; instr must not retire.
REQ-014 beqz, bnez, jump, jumpReg  in  1 each  decoded control for the current instr.
REQ-015 value  in  26  J/JAL offset field; imm16  in  16  branch offset field.
REQ-016 rs1_val  in  32  register-file value of rS1, used for branch test and JR/JALR target.

Function
REQ-017 FSM states: S_REQ and S_ISSUE; there are no other states.
REQ-018 S_REQ: imem_req=1 and imem_addr=fetch_pc; imem_req stays high until imem_ack=1.
REQ-019 S_REQ with imem_ack=1: capture imem_data into instr and fetch_pc into pc_out, then go to S_ISSUE.
REQ-020 imem_ack while imem_req=0 is ignored.
REQ-021 S_ISSUE: instr_valid=1 and imem_req=0; stall=1 holds the state and all outputs unchanged.
REQ-022 S_ISSUE with stall=0: load the next PC into fetch_pc, then go to S_REQ; instr_valid drops in the next cycle.
REQ-023 Next-PC priority 1: jump&jumpReg gives {rs1_val[31:2],2'b00}.
REQ-024 Next-PC priority 2: jump&~jumpReg gives pc_plus4 + sign-extended value.
REQ-025 Next-PC priority 3: beqz&~bnez&(rs1_val==0) gives pc_plus4 + sign-extended imm16.
REQ-026 Next-PC priority 4: bnez&~beqz&(rs1_val!=0) gives pc_plus4 + sign-extended imm16.
REQ-027 Next-PC otherwise: pc_plus4. beqz and bnez both set counts as not taken.
REQ-028 Address arithmetic is 32-bit modulo 2^32: FFFFFFFC+4 gives 00000000, and a negative offset below 0 wraps.
REQ-029 Computed targets have bits [1:0] forced to 00.
REQ-030 Minimum throughput is 2 cycles per instruction (ack in the first S_REQ cycle, no stall).
REQ-031 Controls are sampled only in S_ISSUE with stall=0; their values in S_REQ are ignored.

Reset
REQ-032 reset=1 at a clock edge forces the following values, regardless of state (including mid-request): state=S_REQ, fetch_pc=RESET_PC, instr=0, pc_out=RESET_PC, instr_valid=0.
REQ-033 The imem_req output has no separate reset value; it is driven by state (REQ-018), so it is 1 after reset, and the first post-reset request goes to RESET_PC.
REQ-034 An imem_ack in the cycle reset is high is discarded.

Configuration
REQ-035 Macro IFETCH_PERF_CNT_EN defined: add outputs fetch_cnt[31:0] and redirect_cnt[31:0], both reset to 0.
REQ-036 fetch_cnt increments on each S_REQ->S_ISSUE transition; redirect_cnt increments on each S_ISSUE exit whose next PC is not pc_plus4. Both wrap at 2^32.
REQ-037 Macro IFETCH_PERF_CNT_EN undefined: these ports and counters are absent; all other behaviour is identical.

Verification
REQ-038 Reset with RESET_PC=0, ack at the same cycle as each req, data=0x20010005, stall=0 -> imem_addr sequence 0,4,8; instr_valid high every second cycle.
REQ-039 pc=0x100, beqz=1, rs1_val=0, imm16=0xFFF0 -> next imem_addr 0xF4; with rs1_val=1 -> 0x104.
REQ-040 pc=0x200, jump=1, jumpReg=1, rs1_val=0x00001237 -> next imem_addr 0x1234; pc_plus4=0x204 throughout S_ISSUE.
REQ-041 stall=1 for 5 cycles in S_ISSUE with jump=1, value=0x40 -> instr/pc_out constant and imem_req=0 for 5 cycles; on release imem_addr=pc+4+0x40.
REQ-042 Ack delayed 3 cycles; reset asserted in the 2nd waiting cycle -> req re-issued to RESET_PC; the late ack data is not captured.
REQ-043 pc=0xFFFFFFFC, no branch -> next imem_addr 0x00000000; with IFETCH_PERF_CNT_EN defined, after 3 fetches and 1 taken jump -> fetch_cnt=3, redirect_cnt=1.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch: S_REQ issues imem_req at fetch_pc, S_ISSUE holds instr until stall drops; optional IFETCH_PERF_CNT_EN counters.
// Latency: 1 cycle from imem_ack to instr_valid; 2 cycles per instruction minimum.
// Backpressure: stall holds S_ISSUE with all outputs frozen; imem_req stays high until imem_ack.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   input  logic        stall,
   input  logic        beqz,
   input  logic        bnez,
   input  logic        jump,
   input  logic        jumpReg,
   input  logic [25:0] value,
   input  logic [15:0] imm16,
   input  logic [31:0] rs1_val
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] redirect_cnt
`endif
);

   typedef enum logic {S_REQ = 1'b0, S_ISSUE = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic [31:0] target_raw;
   logic [31:0] next_pc;
   logic        redirect;
   logic        issue_done;
   logic        fetch_done;

   assign imem_req    = (state_q == S_REQ);
   assign imem_addr   = {fetch_pc_q[31:2], 2'b00};
   assign instr_valid = (state_q == S_ISSUE);
   assign instr       = instr_q;
   assign pc_out      = pc_out_q;
   assign pc_plus4    = pc_out_q + 32'd4;

   always_comb begin
      target_raw = pc_plus4;
      if (jump && jumpReg)
         target_raw = {rs1_val[31:2], 2'b00};
      else if (jump)
         target_raw = pc_plus4 + {{6{value[25]}}, value};
      else if (beqz && !bnez && (rs1_val == 32'd0))
         target_raw = pc_plus4 + {{16{imm16[15]}}, imm16};
      else if (bnez && !beqz && (rs1_val != 32'd0))
         target_raw = pc_plus4 + {{16{imm16[15]}}, imm16};
      next_pc  = {target_raw[31:2], 2'b00};
      redirect = (next_pc != pc_plus4);
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      instr_d    = instr_q;
      pc_out_d   = pc_out_q;
      fetch_done = 1'b0;
      issue_done = 1'b0;
      case (state_q)
         S_REQ: begin
            if (imem_ack) begin
               instr_d    = imem_data;
               pc_out_d   = {fetch_pc_q[31:2], 2'b00};
               state_d    = S_ISSUE;
               fetch_done = 1'b1;
            end
         end
         S_ISSUE: begin
            if (!stall) begin
               fetch_pc_d = next_pc;
               state_d    = S_REQ;
               issue_done = 1'b1;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_REQ;
         fetch_pc_q <= RESET_PC;
         instr_q    <= 32'd0;
         pc_out_q   <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         instr_q    <= instr_d;
         pc_out_q   <= pc_out_d;
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] redirect_cnt_q, redirect_cnt_d;

   always_comb begin
      fetch_cnt_d    = fetch_cnt_q + {31'd0, fetch_done};
      redirect_cnt_d = redirect_cnt_q + {31'd0, issue_done & redirect};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt_q    <= 32'd0;
         redirect_cnt_q <= 32'd0;
      end else begin
         fetch_cnt_q    <= fetch_cnt_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   assign fetch_cnt    = fetch_cnt_q;
   assign redirect_cnt = redirect_cnt_q;
`else
   // Handshake strobes only feed the counters; keep them referenced in the lean build.
   logic unused_strobes;
   assign unused_strobes = fetch_done ^ issue_done ^ redirect;
`endif

endmodule
